// File: rtl/ocm_arbiter.sv
// ocm_arbiter: round-robin arbiter giving N_CORES cores one 3-cycle access each to a shared
// synchronous-read on-chip memory. Atomic locking is compiled in only with `define OCM_ARB_LOCK_EN.
module ocm_arbiter #(
  parameter int N_CORES   = 4,
  parameter int ADDR_BITS = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CORES-1:0]             i_req,
  input  logic [N_CORES-1:0]             i_wr,
  input  logic [N_CORES-1:0]             i_lock,
  input  logic [N_CORES*ADDR_BITS-1:0]   i_addr,
  input  logic [N_CORES*32-1:0]          i_wdata,
  input  logic [N_CORES*4-1:0]           i_be,
  output logic [N_CORES-1:0]             o_grant,
  output logic [31:0]                    o_rdata,
  output logic                           o_mem_en,
  output logic                           o_mem_we,
  output logic [ADDR_BITS-1:0]           o_mem_addr,
  output logic [31:0]                    o_mem_wdata,
  output logic [3:0]                     o_mem_be,
  input  logic [31:0]                    i_mem_rdata,
  output logic                           o_locked
);

  // state  | meaning
  // IDLE   | sample requests, pick winner, latch its access
  // ACCESS | memory port driven with the latched access
  // RESP   | grant pulse to winner, read data returned

  localparam int IDXW = $clog2(N_CORES);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        winner_q, winner_d;
  logic [IDXW-1:0]        last_q, last_d;
  logic                   wr_q, wr_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic [3:0]             mem_be_q, mem_be_d;
  logic [N_CORES-1:0]     grant_q, grant_d;

  logic [N_CORES-1:0]     elig;
  logic                   found;
  logic [IDXW-1:0]        win_idx;
  logic [IDXW-1:0]        cand;

`ifdef OCM_ARB_LOCK_EN
  logic                   lock_q, lock_d;
  logic [IDXW-1:0]        owner_q, owner_d;

  assign elig     = lock_q ? (i_req & ({{(N_CORES-1){1'b0}}, 1'b1} << owner_q)) : i_req;
  assign o_locked = lock_q;
`else
  logic                   unused_lock;

  assign unused_lock = ^i_lock;
  assign elig        = i_req;
  assign o_locked    = 1'b0;
`endif

  // Rotating search: first eligible request at or after last_winner+1 wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      cand = IDXW'((int'(last_q) + k) % N_CORES);
      if (!found && elig[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    last_d      = last_q;
    wr_d        = wr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_be_d    = '0;
    grant_d     = '0;
`ifdef OCM_ARB_LOCK_EN
    lock_d      = lock_q;
    owner_d     = owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = ACCESS;
          winner_d    = win_idx;
          last_d      = win_idx;
          wr_d        = i_wr[win_idx];
          mem_en_d    = 1'b1;
          mem_we_d    = i_wr[win_idx];
          mem_addr_d  = i_addr[int'(win_idx)*ADDR_BITS +: ADDR_BITS];
          mem_wdata_d = i_wdata[int'(win_idx)*32 +: 32];
          mem_be_d    = i_be[int'(win_idx)*4 +: 4];
`ifdef OCM_ARB_LOCK_EN
          // Only the owner can win while locked, so its i_lock alone decides keep/release.
          lock_d      = i_lock[win_idx];
          owner_d     = win_idx;
`endif
        end
      end
      ACCESS: begin
        state_d           = RESP;
        grant_d[winner_q] = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      winner_q    <= '0;
      last_q      <= IDXW'(N_CORES - 1);
      wr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      grant_q     <= '0;
`ifdef OCM_ARB_LOCK_EN
      lock_q      <= 1'b0;
      owner_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      last_q      <= last_d;
      wr_q        <= wr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      grant_q     <= grant_d;
`ifdef OCM_ARB_LOCK_EN
      lock_q      <= lock_d;
      owner_q     <= owner_d;
`endif
    end
  end

  assign o_grant     = grant_q;
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_be    = mem_be_q;
  // Memory data arrives the cycle after o_mem_en, which is exactly the grant cycle.
  assign o_rdata     = (|grant_q && !wr_q) ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_ocm_arbiter.sv
// tb_ocm_arbiter: directed vector table, hand-written corner sequences, and randomized traffic
// checked against a transaction-level reference model with its own memory image.
module tb_ocm_arbiter;

  localparam int N  = 4;
  localparam int AB = 12;

  logic            clk;
  logic            rst;
  logic [N-1:0]    i_req, i_wr, i_lock;
  logic [N*AB-1:0] i_addr;
  logic [N*32-1:0] i_wdata;
  logic [N*4-1:0]  i_be;
  logic [N-1:0]    o_grant;
  logic [31:0]     o_rdata;
  logic            o_mem_en, o_mem_we;
  logic [AB-1:0]   o_mem_addr;
  logic [31:0]     o_mem_wdata;
  logic [3:0]      o_mem_be;
  logic [31:0]     i_mem_rdata;
  logic            o_locked;

  int n_checks = 0;
  int n_err    = 0;

  ocm_arbiter #(.N_CORES(N), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_lock(i_lock),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_be(i_be),
    .o_grant(o_grant), .o_rdata(o_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_rdata(i_mem_rdata), .o_locked(o_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory attached to the DUT's memory port.
  logic [31:0] mem [0:4095];
  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 32'h0;
    mem[12'h010] = 32'hDEADBEEF;
    i_mem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      if (o_mem_en) begin
        if (o_mem_we) begin
          for (int b = 0; b < 4; b++)
            if (o_mem_be[b]) mem[o_mem_addr][8*b +: 8] = o_mem_wdata[8*b +: 8];
        end else begin
          i_mem_rdata <= mem[o_mem_addr];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [3:0] g, input logic [31:0] rd,
                                        input logic en, input logic we, input logic [11:0] a,
                                        input logic [31:0] wd, input logic [3:0] be,
                                        input logic lk);
    return {41'b0, g, rd, en, we, a, wd, be, lk};
  endfunction

  function automatic logic [127:0] outs();
    return pack(o_grant, o_rdata, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_locked);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [3:0] req, input logic [3:0] wr, input logic [3:0] lock,
                         input logic [11:0] addr, input logic [31:0] wd, input logic [3:0] be);
    i_req  = req;
    i_wr   = wr;
    i_lock = lock;
    for (int c = 0; c < N; c++) begin
      i_addr[c*AB +: AB]  = addr;
      i_wdata[c*32 +: 32] = wd;
      i_be[c*4 +: 4]      = be;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_all(4'b0, 4'b0, 4'b0, 12'h0, 32'h0, 4'h0);
    step();
    chk("reset_state", outs(), 128'h0);
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  exp_grant;
    logic [31:0] exp_rdata;
  } vec_t;

  // Reference model state (transaction level)
  int          m_phase, m_core, m_last, m_owner;
  logic        m_wr, m_lock;
  logic [11:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic [31:0] ref_mem [0:7];
  logic [N-1:0] pend;

  task automatic model_reset();
    m_phase = 0;
    m_last  = N - 1;
    m_lock  = 1'b0;
    m_owner = 0;
    m_core  = 0;
  endtask

  function automatic logic [127:0] model_exp();
    logic act, rsp;
    act = (m_phase == 1);
    rsp = (m_phase == 2);
    return pack(rsp ? 4'(1 << m_core) : 4'h0,
                (rsp && !m_wr) ? m_rdata : 32'h0,
                act, act && m_wr,
                act ? m_addr : 12'h0, act ? m_wdata : 32'h0, act ? m_be : 4'h0,
                m_lock);
  endfunction

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic model_edge();
    logic [N-1:0] elig;
    logic hit;
    int c;
    case (m_phase)
      0: begin
        elig = i_req;
`ifdef OCM_ARB_LOCK_EN
        if (m_lock) elig = i_req & 4'(1 << m_owner);
`endif
        hit = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!hit && elig[c]) begin
            hit     = 1'b1;
            m_core  = c;
            m_last  = c;
            m_wr    = i_wr[c];
            m_addr  = i_addr[c*AB +: AB];
            m_wdata = i_wdata[c*32 +: 32];
            m_be    = i_be[c*4 +: 4];
`ifdef OCM_ARB_LOCK_EN
            m_lock  = i_lock[c];
            m_owner = c;
`endif
          end
        end
        if (hit) m_phase = 1;
      end
      1: begin
        if (m_wr) begin
          for (int b = 0; b < 4; b++)
            if (m_be[b]) ref_mem[m_addr[2:0]][8*b +: 8] = m_wdata[8*b +: 8];
        end else begin
          m_rdata = ref_mem[m_addr[2:0]];
        end
        m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic drive_rand();
    for (int c = 0; c < N; c++) begin
      if (pend[c] && m_phase != 0 && m_core == c) begin
        if (m_phase == 2 || $urandom_range(0, 1) == 1) begin
          pend[c]             = 1'b0;
          i_req[c]            = 1'b0;
          i_wr[c]             = 1'($urandom);
          i_addr[c*AB +: AB]  = 12'($urandom);
          i_wdata[c*32 +: 32] = $urandom;
        end
      end else if (!pend[c] && !(m_phase != 0 && m_core == c) && $urandom_range(0, 3) == 0) begin
        pend[c]             = 1'b1;
        i_req[c]            = 1'b1;
        i_wr[c]             = 1'($urandom);
        i_lock[c]           = 1'($urandom);
        i_addr[c*AB +: AB]  = 12'h100 + 12'($urandom_range(0, 7));
        i_wdata[c*32 +: 32] = $urandom;
        i_be[c*4 +: 4]      = 4'($urandom);
      end
    end
  endtask

  initial begin
    vec_t vecs [9];
    logic [3:0] eg;

    vecs[0] = '{4'b0001, 4'b0000, 12'h010, 32'h0,        4'hF,    4'b0001, 32'hDEADBEEF};
    vecs[1] = '{4'b1111, 4'b0000, 12'h010, 32'h0,        4'hF,    4'b0010, 32'hDEADBEEF};
    vecs[2] = '{4'b0011, 4'b0000, 12'h030, 32'h0,        4'hF,    4'b0001, 32'h0};
    vecs[3] = '{4'b1001, 4'b0000, 12'h030, 32'h0,        4'hF,    4'b1000, 32'h0};
    vecs[4] = '{4'b0110, 4'b0000, 12'h030, 32'h0,        4'hF,    4'b0010, 32'h0};
    vecs[5] = '{4'b0010, 4'b0000, 12'h030, 32'h0,        4'hF,    4'b0010, 32'h0};
    vecs[6] = '{4'b0100, 4'b0100, 12'h020, 32'hA5A5A5A5, 4'b0011, 4'b0100, 32'h0};
    vecs[7] = '{4'b0100, 4'b0000, 12'h020, 32'h0,        4'hF,    4'b0100, 32'h0000A5A5};
    vecs[8] = '{4'b1100, 4'b0000, 12'h020, 32'h0,        4'hF,    4'b1000, 32'h0000A5A5};

    rst = 1'b1;
    set_all(4'b0, 4'b0, 4'b0, 12'h0, 32'h0, 4'h0);
    do_reset();

    // Directed vectors: one full access each, requests dropped once sampled.
    for (int i = 0; i < 9; i++) begin
      set_all(vecs[i].req, vecs[i].wr, 4'b0, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      step();
      chk($sformatf("vec%0d_access", i), {o_mem_en, o_mem_we, o_mem_addr},
          {1'b1, |(vecs[i].wr & vecs[i].exp_grant), vecs[i].addr});
      i_req = 4'b0;
      step();
      chk($sformatf("vec%0d_grant", i), o_grant, vecs[i].exp_grant);
      chk($sformatf("vec%0d_rdata", i), o_rdata, vecs[i].exp_rdata);
      step();
    end

    // All cores held requesting: grants 0,1,2,3,0 every third cycle.
    do_reset();
    set_all(4'b1111, 4'b0, 4'b0, 12'h030, 32'h0, 4'hF);
    for (int s = 1; s <= 15; s++) begin
      step();
      eg = (s % 3 == 2) ? 4'(1 << ((s / 3) % N)) : 4'h0;
      chk($sformatf("rr_cycle%0d", s), o_grant, eg);
    end

    // Reset during ACCESS of core 1: access dropped, pointer back to core 0 first.
    do_reset();
    set_all(4'b0010, 4'b0, 4'b0, 12'h010, 32'h0, 4'hF);
    step();
    chk("abort_access_before", o_mem_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_async_clear", outs(), 128'h0);
    i_req = 4'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("abort_no_grant", o_grant, 4'h0);
    i_req = 4'b1001;
    step();
    i_req = 4'b0;
    step();
    chk("abort_next_core0", o_grant, 4'b0001);
    step();

    // Core 3 drops its request and changes address mid-access: still granted with latched access.
    do_reset();
    set_all(4'b1000, 4'b0, 4'b0, 12'h010, 32'h0, 4'hF);
    step();
    chk("drop_access_addr", o_mem_addr, 12'h010);
    i_req = 4'b0;
    i_addr[3*AB +: AB] = 12'h020;
    step();
    chk("drop_grant", {o_grant, o_rdata}, {4'b1000, 32'hDEADBEEF});
    step();

`ifdef OCM_ARB_LOCK_EN
    // Core 1 locked read, then unlocking write, before waiting core 0 is served.
    do_reset();
    set_all(4'b0010, 4'b0, 4'b0010, 12'h010, 32'h0, 4'hF);
    step();
    chk("lock_set", o_locked, 1'b1);
    i_req[0] = 1'b1;
    step();
    chk("lock_grant1", {o_grant, o_locked}, {4'b0010, 1'b1});
    i_wr[1]   = 1'b1;
    i_lock[1] = 1'b0;
    step();
    chk("lock_held_idle", o_locked, 1'b1);
    step();
    chk("lock_release", {o_mem_en, o_mem_we, o_locked}, {1'b1, 1'b1, 1'b0});
    step();
    chk("lock_grant2", o_grant, 4'b0010);
    i_req[1] = 1'b0;
    step();
    step();
    i_req[0] = 1'b0;
    step();
    chk("lock_then_core0", o_grant, 4'b0001);
    step();
`endif

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    pend = '0;
    for (int a = 0; a < 8; a++) ref_mem[a] = 32'h0;
    for (int a = 12'h100; a < 12'h108; a++) mem[a] = 32'h0;
    drive_rand();
    model_edge();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      chk("rand_cycle", outs(), model_exp());
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #1;
        chk("rand_reset", outs(), 128'h0);
        model_reset();
        pend  = '0;
        i_req = '0;
        continue;
      end
      drive_rand();
      model_edge();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
